cache_evict_fill: RTL
=====================

Name: cache_evict_fill

Overview:
- Miss-handling sequencer that sits directly downstream of the cache victim-way selector.
- On a cache miss it latches the one-hot victim way and the line addresses.
- If the victim is dirty, it writes the victim line back over a beat-based bus, then fetches the new line into that way.
- It ends with a single update cycle that sets valid, clears dirty and updates replacement state, stalling the cache pipeline throughout.

Parameters:
- NUMWAYS, 4, cache associativity; width of the one-hot way vectors.
- PALEN, 32, physical address width.
- LINELEN, 256, cache line size in bits.
- BUSWIDTH, 64, bus beat width in bits; BEATS = LINELEN/BUSWIDTH (must be ≥2, power of 2).
- OFFSETLEN, 5, line offset bits = log2(LINELEN/8).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- CacheMiss  input  1  miss detected by cache pipeline; PAdr/VictimWay/VictimDirty/VictimAdr valid this cycle.
- FlushStage  input  1  pipeline flush; suppresses miss acceptance.
- PAdr  input  PALEN  physical address of missing access.
- VictimWay  input  NUMWAYS  one-hot victim from replacement selector.
- VictimDirty  input  1  dirty bit of the victim way in the addressed set.
- VictimAdr  input  PALEN  line address (tag+set) of the victim line.
- BusReq  output  1  bus transaction request, held high for the whole burst.
- BusWrite  output  1  1 = writeback burst, 0 = fetch burst.
- BusAdr  output  PALEN  beat address.
- BusAck  input  1  beat accepted/returned this cycle.
- BeatCount  output  log2(BEATS)  current beat index (data-array word select).
- FillWayEn  output  NUMWAYS  per-way data write enable, fetch beats only.
- SetValid  output  1  set valid bit of latched way (UPDATE only).
- ClearDirty  output  1  clear dirty bit of latched way (UPDATE only).
- LRUWriteEn  output  1  update replacement state (UPDATE only).
- SelWay  output  NUMWAYS  latched victim way, drives tag/valid/dirty way select.
- Stall  output  1  hold cache pipeline.

Behaviour:
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- Reset (reset==0 at edge, any state incl. mid-burst):
  - state=IDLE, BeatCnt=0, WayReg=0, address regs=0.
  - All outputs 0 from the next cycle; an in-flight burst is abandoned.
- IDLE:
  - Accept when CacheMiss & ~FlushStage.
  - On accept: WayReg←VictimWay, FetchAdr←PAdr[PALEN-1:OFFSETLEN], WbAdr←VictimAdr[PALEN-1:OFFSETLEN].
  - Next state: WRITEBACK if VictimDirty, else FETCH.
  - Stall = CacheMiss & ~FlushStage (combinational); otherwise 0.
- WRITEBACK / FETCH:
  - BusReq=1. BusWrite=1 in WRITEBACK, 0 in FETCH.
  - BusAdr = {line addr, BeatCnt, zeros(OFFSETLEN−log2(BEATS))}; line addr is WbAdr in WRITEBACK, FetchAdr in FETCH.
  - BeatCnt increments only on BusAck; BusAdr/BeatCount hold while BusAck=0.
  - On BusAck with BeatCnt==BEATS−1: BeatCnt wraps to 0. WRITEBACK→FETCH; FETCH→UPDATE.
  - FillWayEn = WayReg when FETCH & BusAck, else 0.
  - Stall=1.
- UPDATE (exactly one cycle):
  - SetValid=1, ClearDirty=1, LRUWriteEn=1, Stall=1, BusReq=0; then →IDLE.
- SelWay = WayReg in all non-IDLE states; VictimWay in IDLE.
- Latched values are immune to input changes after accept.
- FlushStage is ignored outside IDLE: the burst and UPDATE always complete.
- CacheMiss outside IDLE is ignored; no queueing.
- Latency, clean miss with BusAck every cycle: accept cycle + BEATS fetch cycles + 1 UPDATE; Stall low in cycle BEATS+2 after accept.
- Dirty miss adds BEATS cycles.

Optional Feature:
- Macro CACHE_EVICT_FILL_PERF_EN.
- When defined, adds outputs MissCount[31:0] and WritebackCount[31:0]:
  - MissCount increments on each accepted miss.
  - WritebackCount increments on each entry to WRITEBACK.
  - Both wrap at 2^32 and are cleared by reset.
- When undefined, neither port nor counter logic exists.

Test Plan:
- Clean miss: PAdr=0x00001234, VictimWay=4'b0100, VictimDirty=0, BusAck always 1
  -> BusAdr 0x1220,0x1228,0x1230,0x1238, BusWrite=0, FillWayEn=0100 on each beat.
  -> UPDATE cycle 5 with SetValid/ClearDirty/LRUWriteEn=1; Stall=0 at cycle 6.
- Dirty miss: VictimAdr=0x00008A20, VictimDirty=1, PAdr=0x00001234
  -> BusWrite=1 at 0x8A20..0x8A38 with FillWayEn=0, then fetch 0x1220..0x1238; UPDATE at cycle 9.
- Bus backpressure: BusAck=1 only every other cycle during fetch -> BeatCount/BusAdr hold on non-ack cycles; exactly 4 FillWayEn pulses.
- Reset (reset=0) during fetch beat 2 -> next cycle state IDLE, BusReq=0, BeatCount=0, Stall=0; a new miss is then accepted normally.
- FlushStage=1 with CacheMiss=1 in IDLE -> Stall=0, no BusReq. Flush during FETCH -> burst and UPDATE still complete.
- VictimWay changed to 4'b0001 mid-burst -> FillWayEn/SelWay remain 4'b0100.
- With CACHE_EVICT_FILL_PERF_EN: one clean miss plus one dirty miss -> MissCount=2, WritebackCount=1.

Source files
------------

// File: rtl/cache_evict_fill.sv
// Miss sequencer: latches victim way, writes back a dirty victim, fetches the new line, then updates tags.
// Optional CACHE_EVICT_FILL_PERF_EN adds MissCount/WritebackCount performance counters.
module cache_evict_fill #(
    parameter int NUMWAYS   = 4,
    parameter int PALEN     = 32,
    parameter int LINELEN   = 256,
    parameter int BUSWIDTH  = 64,
    parameter int OFFSETLEN = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            CacheMiss,
    input  logic                            FlushStage,
    input  logic [PALEN-1:0]                PAdr,
    input  logic [NUMWAYS-1:0]              VictimWay,
    input  logic                            VictimDirty,
    input  logic [PALEN-1:0]                VictimAdr,
    output logic                            BusReq,
    output logic                            BusWrite,
    output logic [PALEN-1:0]                BusAdr,
    input  logic                            BusAck,
    output logic [$clog2(LINELEN/BUSWIDTH)-1:0] BeatCount,
    output logic [NUMWAYS-1:0]              FillWayEn,
    output logic                            SetValid,
    output logic                            ClearDirty,
    output logic                            LRUWriteEn,
    output logic [NUMWAYS-1:0]              SelWay,
`ifdef CACHE_EVICT_FILL_PERF_EN
    output logic [31:0]                     MissCount,
    output logic [31:0]                     WritebackCount,
`endif
    output logic                            Stall
);

    localparam int BEATS    = LINELEN / BUSWIDTH;
    localparam int BEATBITS = $clog2(BEATS);
    localparam int LINEBITS = PALEN - OFFSETLEN;
    localparam int BEATSH   = OFFSETLEN - BEATBITS;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FETCH     = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    logic [1:0]          state;
    logic [BEATBITS-1:0] beatcnt;
    logic [NUMWAYS-1:0]  wayreg;
    logic [LINEBITS-1:0] fetchadr;
    logic [LINEBITS-1:0] wbadr;
    logic [LINEBITS-1:0] lineadr;
    logic                accept;
    logic                lastbeat;
    logic                inburst;
    logic                unused_lowbits;

    assign accept   = (state == IDLE) & CacheMiss & ~FlushStage;
    assign inburst  = (state == WRITEBACK) | (state == FETCH);
    assign lastbeat = BusAck & (beatcnt == BEATBITS'(BEATS - 1));
    assign unused_lowbits = ^{PAdr[OFFSETLEN-1:0], VictimAdr[OFFSETLEN-1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            beatcnt  <= '0;
            wayreg   <= '0;
            fetchadr <= '0;
            wbadr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        wayreg   <= VictimWay;
                        fetchadr <= PAdr[PALEN-1:OFFSETLEN];
                        wbadr    <= VictimAdr[PALEN-1:OFFSETLEN];
                        state    <= VictimDirty ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: begin
                    if (BusAck) beatcnt <= beatcnt + 1'b1;
                    if (lastbeat) state <= FETCH;
                end
                FETCH: begin
                    if (BusAck) beatcnt <= beatcnt + 1'b1;
                    if (lastbeat) state <= UPDATE;
                end
                UPDATE: state <= IDLE;
            endcase
        end
    end

    // Beat index sits just above the bus-word byte offset within the line
    assign lineadr   = (state == WRITEBACK) ? wbadr : fetchadr;
    assign BusAdr    = {lineadr, {OFFSETLEN{1'b0}}}
                     | (PALEN'(beatcnt) << BEATSH);
    assign BusReq    = inburst;
    assign BusWrite  = (state == WRITEBACK);
    assign BeatCount = beatcnt;
    assign FillWayEn = (state == FETCH && BusAck) ? wayreg : '0;
    assign SetValid   = (state == UPDATE);
    assign ClearDirty = (state == UPDATE);
    assign LRUWriteEn = (state == UPDATE);
    assign SelWay    = (state == IDLE) ? VictimWay : wayreg;
    assign Stall     = (state == IDLE) ? (CacheMiss & ~FlushStage) : 1'b1;

`ifdef CACHE_EVICT_FILL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            MissCount      <= '0;
            WritebackCount <= '0;
        end else if (accept) begin
            MissCount <= MissCount + 32'd1;
            if (VictimDirty) WritebackCount <= WritebackCount + 32'd1;
        end
    end
`endif

endmodule
